// File: rtl/video_timing_pkg.sv
// Shared constants and types for the pixel-domain video timing generator.
// Holds the 480p60 and 720p60 timing sets plus coordinate widths.
package video_timing_pkg;

   localparam int H_W = 11;
   localparam int V_W = 10;

   // CEA 720x480p60, 27 MHz pixel clock
   localparam int P480_H_ACTIVE = 720;
   localparam int P480_H_FP     = 16;
   localparam int P480_H_SYNC   = 62;
   localparam int P480_H_BP     = 60;
   localparam int P480_V_ACTIVE = 480;
   localparam int P480_V_FP     = 9;
   localparam int P480_V_SYNC   = 6;
   localparam int P480_V_BP     = 30;
   localparam bit P480_HS_POL   = 1'b0;
   localparam bit P480_VS_POL   = 1'b0;

   // CEA 1280x720p60, 74.25 MHz pixel clock
   localparam int P720_H_ACTIVE = 1280;
   localparam int P720_H_FP     = 110;
   localparam int P720_H_SYNC   = 40;
   localparam int P720_H_BP     = 220;
   localparam int P720_V_ACTIVE = 720;
   localparam int P720_V_FP     = 5;
   localparam int P720_V_SYNC   = 5;
   localparam int P720_V_BP     = 20;
   localparam bit P720_HS_POL   = 1'b1;
   localparam bit P720_VS_POL   = 1'b1;

   localparam int LOCK_WAIT_DEF = 1024;

   typedef enum logic {
      WAIT_LOCK = 1'b0,
      RUN       = 1'b1
   } state_t;

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle from the generator to the renderer and TMDS encoder.
interface video_timing_if;
   import video_timing_pkg::*;

   logic           running;
   logic           hsync;
   logic           vsync;
   logic           de;
   logic [H_W-1:0] x;
   logic [V_W-1:0] y;
   logic           line_start;
   logic           frame_start;

   modport master (
      output running, hsync, vsync, de,
      output x, y, line_start, frame_start
   );

   modport slave (
      input running, hsync, vsync, de,
      input x, y, line_start, frame_start
   );

endinterface

// File: rtl/video_timing_gen_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/video_timing_gen.sv
// Lock-qualified raster timing generator: sync, DE, coordinates, strobes.
// All outputs are registered from (state, h, v) with one cycle of latency.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE  = P480_H_ACTIVE,
   parameter int H_FP      = P480_H_FP,
   parameter int H_SYNC    = P480_H_SYNC,
   parameter int H_BP      = P480_H_BP,
   parameter int V_ACTIVE  = P480_V_ACTIVE,
   parameter int V_FP      = P480_V_FP,
   parameter int V_SYNC    = P480_V_SYNC,
   parameter int V_BP      = P480_V_BP,
   parameter bit HS_POL    = P480_HS_POL,
   parameter bit VS_POL    = P480_VS_POL,
   parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pll_lock,
   video_timing_if.master  vt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LCW     = $clog2(LOCK_WAIT + 1);

   localparam logic [H_W-1:0] L_HA   = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] L_HS0  = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] L_HS1  = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [H_W-1:0] L_HEND = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] L_VA   = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] L_VS0  = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] L_VS1  = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_W-1:0] L_VEND = V_W'(V_TOTAL - 1);
   localparam logic [LCW-1:0] L_LAST = LCW'(LOCK_WAIT - 1);

   if (H_TOTAL > 2048) begin : g_h_chk
      $error("video_timing_gen: H_TOTAL exceeds 11-bit counter");
   end
   if (V_TOTAL > 1024) begin : g_v_chk
      $error("video_timing_gen: V_TOTAL exceeds 10-bit counter");
   end

   logic           w_lock_s;
   state_t         r_state, w_state_nxt;
   logic [LCW-1:0] r_lock_cnt, w_lock_nxt;
   logic [H_W-1:0] r_h, w_h_nxt;
   logic [V_W-1:0] r_v, w_v_nxt;
   logic           w_de, w_hs_act, w_vs_act;

   logic           r_running, r_hs, r_vs, r_de, r_ls, r_fs;
   logic [H_W-1:0] r_x;
   logic [V_W-1:0] r_y;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (pll_lock),
      .o_q (w_lock_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= WAIT_LOCK;
         r_lock_cnt <= '0;
         r_h        <= '0;
         r_v        <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_nxt;
         r_h        <= w_h_nxt;
         r_v        <= w_v_nxt;
      end
   end

   // Leaving on the LOCK_WAIT-th good cycle keeps first-run latency at LOCK_WAIT+2
   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock_cnt;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      unique case (r_state)
         WAIT_LOCK: begin
            if (!w_lock_s) begin
               w_lock_nxt = '0;
            end else if (r_lock_cnt == L_LAST) begin
               w_state_nxt = RUN;
               w_lock_nxt  = '0;
               w_h_nxt     = '0;
               w_v_nxt     = '0;
            end else begin
               w_lock_nxt = r_lock_cnt + 1'b1;
            end
         end
         RUN: begin
            if (!w_lock_s) begin
               w_state_nxt = WAIT_LOCK;
               w_lock_nxt  = '0;
               w_h_nxt     = '0;
               w_v_nxt     = '0;
            end else if (r_h == L_HEND) begin
               w_h_nxt = '0;
               w_v_nxt = (r_v == L_VEND) ? '0 : r_v + 1'b1;
            end else begin
               w_h_nxt = r_h + 1'b1;
            end
         end
         default: begin
            w_state_nxt = WAIT_LOCK;
         end
      endcase
   end

   assign w_de     = (r_h < L_HA) && (r_v < L_VA);
   assign w_hs_act = (r_h >= L_HS0) && (r_h < L_HS1);
   assign w_vs_act = (r_v >= L_VS0) && (r_v < L_VS1);

   always_ff @(posedge clk) begin
      if (rst || r_state == WAIT_LOCK) begin
         r_running <= 1'b0;
         r_hs      <= ~HS_POL;
         r_vs      <= ~VS_POL;
         r_de      <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_ls      <= 1'b0;
         r_fs      <= 1'b0;
      end else begin
         r_running <= 1'b1;
         r_hs      <= w_hs_act ? HS_POL : ~HS_POL;
         r_vs      <= w_vs_act ? VS_POL : ~VS_POL;
         r_de      <= w_de;
         r_x       <= w_de ? r_h : '0;
         r_y       <= w_de ? r_v : '0;
         r_ls      <= (r_h == '0);
         r_fs      <= (r_h == '0) && (r_v == '0);
      end
   end

   assign vt.running     = r_running;
   assign vt.hsync       = r_hs;
   assign vt.vsync       = r_vs;
   assign vt.de          = r_de;
   assign vt.x           = r_x;
   assign vt.y           = r_y;
   assign vt.line_start  = r_ls;
   assign vt.frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster.
// Expected outputs come from a lock-streak / elapsed-time model.
module tb_video_timing_gen;
   import video_timing_pkg::*;

   localparam int HA = 20, HF = 3, HS = 4, HB = 5;
   localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int LW = 16;

   typedef struct packed {
      logic           run;
      logic           hs;
      logic           vs;
      logic           de;
      logic [H_W-1:0] x;
      logic [V_W-1:0] y;
      logic           ls;
      logic           fs;
   } obs_t;

   logic clk;
   logic rst;
   logic pll_lock;

   video_timing_if vif ();

   video_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .HS_POL (1'b0), .VS_POL (1'b0), .LOCK_WAIT (LW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pll_lock (pll_lock),
      .vt       (vif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   obs_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_cyc   = 0;

   // Model state: good-lock streak per edge and recent resets
   int   s0 = 0, s1 = 0, s2 = 0, s3 = 0;
   bit   r0 = 1, r1 = 1, r2 = 1;
   int   streak = 0;

   function automatic obs_t expect_out(int st3, bit any_rst);
      obs_t e;
      int   t, h, v;
      e = '{run: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0,
            x: '0, y: '0, ls: 1'b0, fs: 1'b0};
      if (!any_rst && st3 >= LW) begin
         t = st3 - LW;
         h = t % HT;
         v = (t / HT) % VT;
         e.run = 1'b1;
         e.de  = (h < HA) && (v < VA);
         e.x   = e.de ? H_W'(h) : '0;
         e.y   = e.de ? V_W'(v) : '0;
         e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
         e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
         e.ls  = (h == 0);
         e.fs  = (h == 0) && (v == 0);
      end
      return e;
   endfunction

   task automatic drive(input bit lk, input bit rs);
      @(negedge clk);
      pll_lock = lk;
      rst      = rs;
      if (rs || !lk) streak = 0;
      else           streak = streak + 1;
      s3 = s2; s2 = s1; s1 = s0; s0 = streak;
      r2 = r1; r1 = r0; r0 = rs;
      q_exp.push_back(expect_out(s3, r0 | r1 | r2));
   endtask

   always begin
      obs_t a, e;
      @(posedge clk);
      #1;
      if (q_exp.size() != 0) begin
         e = q_exp.pop_front();
         a = '{run: vif.running, hs: vif.hsync, vs: vif.vsync,
               de: vif.de, x: vif.x, y: vif.y,
               ls: vif.line_start, fs: vif.frame_start};
         n_tests++;
         n_cyc++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d got run=%0b hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b want run=%0b hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b",
                     n_cyc, a.run, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
                     e.run, e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
         end
      end
   end

   initial begin
      int n, k;
      pll_lock = 1'b0;
      rst      = 1'b1;
      repeat (4) drive(1'b0, 1'b1);
      repeat (1000) drive(1'b0, 1'b0);
      // clean qualification then several full frames
      repeat (1500) drive(1'b1, 1'b0);
      // glitch during qualification restarts the count
      repeat (2) drive(1'b1, 1'b1);
      repeat (12) drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      repeat (80) drive(1'b1, 1'b0);
      // lock drop mid-frame, then requalify
      repeat (LW + 2 + 3 * HT + 10) drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      repeat (600) drive(1'b1, 1'b0);
      // reset mid-line with lock held high
      repeat (HT + 7) drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      repeat (200) drive(1'b1, 1'b0);
      repeat (40) begin
         n = $urandom_range(5, 900);
         repeat (n) drive(1'b1, 1'b0);
         k = $urandom_range(0, 9);
         if (k == 0) begin
            drive(1'b1, 1'b1);
         end else if (k == 1) begin
            drive(1'b0, 1'b1);
         end else begin
            n = $urandom_range(1, 4);
            repeat (n) drive(1'b0, 1'b0);
         end
      end
      repeat (50) drive(1'b1, 1'b0);
      @(posedge clk);
      #2;
      n_tests++;
      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending want 0", q_exp.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-domain timing generator sitting directly downstream of the rPLL.
- Clocked by the PLL's divided output (27 MHz pixel clock; the 270 MHz serial clock feeds the TMDS serializers elsewhere).
- Qualifies the PLL lock flag, then produces CEA 720x480p60 sync, data-enable, pixel coordinates and frame/line strobes for the pattern/Tetris renderer and TMDS encoder.
- Drops to an idle, blanked state whenever lock is lost.

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 62, hsync width (pixels)
- H_BP, 60, horizontal back porch (pixels); H_TOTAL = 858
- V_ACTIVE, 480, active lines
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 30, vertical back porch (lines); V_TOTAL = 525
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- LOCK_WAIT, 1024, consecutive synchronized-lock cycles required before running

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, synchronous active-high reset
- pll_lock, input, 1, raw PLL lock flag, treated as asynchronous
- running, output, 1, high while timing is generated
- hsync, output, 1, horizontal sync at HS_POL when active
- vsync, output, 1, vertical sync at VS_POL when active
- de, output, 1, active-video data enable
- x, output, 11, active pixel column (0..H_ACTIVE-1), 0 outside active video
- y, output, 10, active line (0..V_ACTIVE-1), 0 outside active video
- line_start, output, 1, one-cycle pulse at h=0 of every line
- frame_start, output, 1, one-cycle pulse at h=0, v=0

Behaviour:
- Reset (rst high at a clk edge):
  - Synchronizer, lock counter, h_cnt and v_cnt cleared; state WAIT_LOCK.
  - Outputs: running=0, hsync=~HS_POL, vsync=~VS_POL, de=0, x=0, y=0, pulses=0.
  - rst has priority over every other event.
- Lock synchronizer: 2 flops, giving lock_s.
- State machine, two states:
  - WAIT_LOCK: lock_cnt increments while lock_s=1 and clears when lock_s=0. When lock_cnt reaches LOCK_WAIT, go to RUN with h_cnt=0, v_cnt=0. running is first observed high exactly LOCK_WAIT+2 edges after pll_lock is first sampled high.
  - RUN: each edge, h_cnt wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0. If lock_s=0, go to WAIT_LOCK and clear lock_cnt, h_cnt and v_cnt.
- Outputs are registered from (state, h_cnt, v_cnt): one cycle latency, all outputs mutually aligned.
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - x = h and y = v when de=1, else 0.
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. Vsync transitions are aligned to h=0 (whole lines).
  - line_start = (h==0).
  - frame_start = (h==0 && v==0).
- In WAIT_LOCK all outputs hold their reset values.
- The first output cycle after entering RUN has de=1, x=0, y=0, line_start=1, frame_start=1.
- Lock loss mid-frame: outputs go idle on the edge after the state returns to WAIT_LOCK. No partial-line completion. Requalification requires the full LOCK_WAIT again.
- Lock glitch in WAIT_LOCK: any lock_s=0 cycle restarts the count.
- Widths: h_cnt 11 bits and v_cnt 10 bits. Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024, checked by elaboration-time assertion.

Decomposition:
- Shared package video_timing_pkg holds:
  - 480p60 constant set (defaults above).
  - 720p60 constant set: 1280/110/40/220, 720/5/5/20, positive polarity.
  - State enum {WAIT_LOCK, RUN}.
  - Coordinate width constants.
- One sub-module: sync_2ff, a generic 2-flop synchronizer used for pll_lock.

Test Plan:
- Reset release with pll_lock=0 for 5000 cycles -> running=0, de=0, hsync=vsync=1 throughout.
- LOCK_WAIT=16; pll_lock rises at cycle 100 and stays high -> running first high at cycle 118. That cycle has de=1, x=0, y=0, frame_start=1.
- Full frame in RUN:
  - line_start period = 858 cycles; frame_start period = 450450 cycles.
  - de high for exactly 345600 cycles per frame.
  - hsync low for 62 cycles starting 736 cycles after each line_start.
  - vsync low for lines 489..494 (6 x 858 = 5148 cycles).
- LOCK_WAIT=16; pll_lock pulses low 1 cycle at lock_cnt=10 during WAIT_LOCK -> count restarts; running delayed accordingly; no output activity.
- pll_lock drops at line 200, pixel 300 -> within 3 cycles running=0, de=0, syncs inactive. Lock regained: new frame starts at x=0, y=0 after LOCK_WAIT+2 cycles.
- rst asserted mid-line in RUN -> all outputs at reset values on the next edge. After release, requalification is required even with pll_lock steadily high.
